// File: rtl/pc_sequencer.sv
// Program-counter unit for the single-cycle MIPS datapath: holds the fetch PC,
// selects the next PC by request priority, captures EPC and keeps a circular RAS.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h8000_0180),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         exc,
  input  logic                         jr_ra,
  input  logic                         jr,
  input  logic [XLEN-1:0]              jr_target,
  input  logic                         jal,
  input  logic                         jump,
  input  logic [25:0]                  instr,
  input  logic                         pcsrc,
  input  logic [15:0]                  branch_imm,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus4,
  output logic [XLEN-1:0]              epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow
);

  localparam int              PTR_W    = $clog2(RAS_DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_count_q, ras_count_d;
  logic             ras_overflow_q, ras_overflow_d;

  logic             ras_push;
  logic [PTR_W-1:0] ras_top_idx;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  logic [XLEN-1:0]  br_offset;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jt_target;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign br_offset = {{(XLEN-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign jt_target = {pc_plus4[XLEN-1:28], instr, 2'b00};

  // The pointer marks the next free slot, so the top of stack sits one below it.
  assign ras_top_idx = ras_ptr_q - PTR_W'(1);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    pc_d           = pc_q;
    epc_d          = epc_q;
    ras_ptr_d      = ras_ptr_q;
    ras_count_d    = ras_count_q;
    ras_overflow_d = ras_overflow_q;
    ras_push       = 1'b0;

    if (exc) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (jr_ra) begin
      if (ras_count_q != '0) begin
        pc_d        = ras_mem[ras_top_idx];
        ras_ptr_d   = ras_top_idx;
        ras_count_d = ras_count_q - CNT_W'(1);
      end else begin
        pc_d = jr_target;
      end
    end else if (jr) begin
      pc_d = jr_target;
    end else if (jal) begin
      pc_d      = jt_target;
      ras_push  = 1'b1;
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      // A full stack keeps its count; the oldest slot is the one being overwritten.
      if (ras_count_q == RAS_FULL) begin
        ras_overflow_d = 1'b1;
      end else begin
        ras_count_d = ras_count_q + CNT_W'(1);
      end
    end else if (jump) begin
      pc_d = jt_target;
    end else if (pcsrc) begin
      pc_d = br_target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_VECTOR;
      epc_q          <= '0;
      ras_ptr_q      <= '0;
      ras_count_q    <= '0;
      ras_overflow_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      ras_ptr_q      <= ras_ptr_d;
      ras_count_q    <= ras_count_d;
      ras_overflow_q <= ras_overflow_d;
    end
  end

  // NOTE: the RAS storage has no reset; ras_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr_q] <= pc_plus4;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign ras_count    = ras_count_q;
  assign ras_overflow = ras_overflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: hand-written reset sequences plus a
// vector table, with expected state queued at drive time and popped after the edge.
module tb_pc_sequencer;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;

  localparam logic [6:0] F_NONE = 7'h00;
  localparam logic [6:0] F_S    = 7'h40;
  localparam logic [6:0] F_X    = 7'h20;
  localparam logic [6:0] F_RA   = 7'h10;
  localparam logic [6:0] F_JR   = 7'h08;
  localparam logic [6:0] F_JL   = 7'h04;
  localparam logic [6:0] F_JP   = 7'h02;
  localparam logic [6:0] F_BR   = 7'h01;

  typedef struct {
    string       name;
    logic [6:0]  flags;   // {stall, exc, jr_ra, jr, jal, jump, pcsrc}
    logic [31:0] tgt;
    logic [25:0] instr;
    logic [15:0] bimm;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc, jr_ra, jr, jal, jump, pcsrc;
  logic [31:0] jr_target;
  logic [25:0] instr;
  logic [15:0] branch_imm;
  logic [31:0] pc, pc_plus4, epc;
  logic [2:0]  ras_count;
  logic        ras_overflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  pc_sequencer #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR(32'h8000_0180),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .exc(exc),
    .jr_ra(jr_ra),
    .jr(jr),
    .jr_target(jr_target),
    .jal(jal),
    .jump(jump),
    .instr(instr),
    .pcsrc(pcsrc),
    .branch_imm(branch_imm),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .epc(epc),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] flags,
                              input logic [31:0] tgt, input logic [25:0] ins,
                              input logic [15:0] bimm, input logic [31:0] e_pc,
                              input logic [31:0] e_epc, input logic [2:0] e_cnt,
                              input logic e_ovf);
    vec_t v;
    v.name = name; v.flags = flags; v.tgt = tgt; v.instr = ins; v.bimm = bimm;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    {stall, exc, jr_ra, jr, jal, jump, pcsrc} = v.flags;
    jr_target  = v.tgt;
    instr      = v.instr;
    branch_imm = v.bimm;
    e.name = v.name; e.pc = v.e_pc; e.epc = v.e_epc; e.cnt = v.e_cnt; e.ovf = v.e_ovf;
    sb_q.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check({e.name, ".pc"}, pc, e.pc);
      check({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
      check({e.name, ".epc"}, epc, e.epc);
      check({e.name, ".ras_count"}, {29'd0, ras_count}, {29'd0, e.cnt});
      check({e.name, ".ras_overflow"}, {31'd0, ras_overflow}, {31'd0, e.ovf});
    end
  endtask

  task automatic step(input vec_t v);
    drive(v);
    collect();
  endtask

  // Assert reset between edges and confirm the state clears without a clock edge.
  task automatic mid_cycle_reset(input string name);
    #2;
    reset = 1'b1;
    #1;
    check({name, ".pc"}, pc, 32'h0);
    check({name, ".epc"}, epc, 32'h0);
    check({name, ".ras_count"}, {29'd0, ras_count}, 32'h0);
    check({name, ".ras_overflow"}, {31'd0, ras_overflow}, 32'h0);
    #2;
    {stall, exc, jr_ra, jr, jal, jump, pcsrc} = F_NONE;
    reset = 1'b0;
    #1;
    check({name, ".pc_after_release"}, pc, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    {stall, exc, jr_ra, jr, jal, jump, pcsrc} = F_NONE;
    jr_target = '0; instr = '0; branch_imm = '0;

    #12;
    reset = 1'b0;
    #1;
    check("release.pc", pc, 32'h0);

    // Build up non-reset state (pc, epc, RAS) before hitting reset mid-operation.
    step(mk("pre_seq1", F_NONE, 0, 0, 0, 32'h4, 32'h0, 3'd0, 1'b0));
    step(mk("pre_seq2", F_NONE, 0, 0, 0, 32'h8, 32'h0, 3'd0, 1'b0));
    step(mk("pre_jal",  F_JL, 0, 26'h40, 0, 32'h100, 32'h0, 3'd1, 1'b0));
    step(mk("pre_exc",  F_X,  0, 0, 0, 32'h8000_0180, 32'h100, 3'd1, 1'b0));
    mid_cycle_reset("reset1");

    step(mk("seq_4", F_NONE, 0, 0, 0, 32'h4, 32'h0, 3'd0, 1'b0));
    step(mk("seq_8", F_NONE, 0, 0, 0, 32'h8, 32'h0, 3'd0, 1'b0));
    step(mk("seq_c", F_NONE, 0, 0, 0, 32'hC, 32'h0, 3'd0, 1'b0));

    vecs.push_back(mk("seq_10",      F_NONE, 0, 0, 0, 32'h10, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("br_back",     F_BR, 0, 0, 16'hFFFE, 32'hC, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("seq_10b",     F_NONE, 0, 0, 0, 32'h10, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("br_fwd",      F_BR, 0, 0, 16'h0003, 32'h20, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("jr_10",       F_JR, 32'h10, 0, 0, 32'h10, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("jal_100",     F_JL, 0, 26'h40, 0, 32'h100, 32'h0, 3'd1, 1'b0));
    vecs.push_back(mk("ret_pop",     F_RA, 32'hDEAD_BEEC, 0, 0, 32'h14, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("ret_empty",   F_RA, 32'hDEAD_BEEC, 0, 0, 32'hDEAD_BEEC, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("prio_jr",     F_JP | F_BR | F_JL | F_JR, 32'h300, 26'h40, 16'h5, 32'h300, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("no_push",     F_RA, 32'h40, 0, 0, 32'h40, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("stall_br",    F_S | F_BR, 0, 0, 16'h5, 32'h40, 32'h0, 3'd0, 1'b0));
    vecs.push_back(mk("stall_exc",   F_S | F_X, 0, 0, 0, 32'h8000_0180, 32'h40, 3'd0, 1'b0));
    vecs.push_back(mk("stall_jal",   F_S | F_JL, 0, 26'h40, 0, 32'h8000_0180, 32'h40, 3'd0, 1'b0));
    vecs.push_back(mk("seq_184",     F_NONE, 0, 0, 0, 32'h8000_0184, 32'h40, 3'd0, 1'b0));
    vecs.push_back(mk("jal_upper",   F_JL, 0, 26'h3, 0, 32'h8000_000C, 32'h40, 3'd1, 1'b0));
    vecs.push_back(mk("ret_upper",   F_RA, 0, 0, 0, 32'h8000_0188, 32'h40, 3'd0, 1'b0));
    vecs.push_back(mk("push_a1",     F_JL, 0, 26'h100, 0, 32'h8000_0400, 32'h40, 3'd1, 1'b0));
    vecs.push_back(mk("push_a2",     F_JL, 0, 26'h200, 0, 32'h8000_0800, 32'h40, 3'd2, 1'b0));
    vecs.push_back(mk("push_a3",     F_JL, 0, 26'h300, 0, 32'h8000_0C00, 32'h40, 3'd3, 1'b0));
    vecs.push_back(mk("push_a4",     F_JL, 0, 26'h400, 0, 32'h8000_1000, 32'h40, 3'd4, 1'b0));
    vecs.push_back(mk("push_a5_ovf", F_JL, 0, 26'h500, 0, 32'h8000_1400, 32'h40, 3'd4, 1'b1));
    vecs.push_back(mk("pop_a5",      F_RA, 32'h1234_0000, 0, 0, 32'h8000_1004, 32'h40, 3'd3, 1'b1));
    vecs.push_back(mk("pop_a4",      F_RA, 32'h1234_0000, 0, 0, 32'h8000_0C04, 32'h40, 3'd2, 1'b1));
    vecs.push_back(mk("pop_a3",      F_RA, 32'h1234_0000, 0, 0, 32'h8000_0804, 32'h40, 3'd1, 1'b1));
    vecs.push_back(mk("pop_a2",      F_RA, 32'h1234_0000, 0, 0, 32'h8000_0404, 32'h40, 3'd0, 1'b1));
    vecs.push_back(mk("pop_fallbk",  F_RA, 32'h1234_0000, 0, 0, 32'h1234_0000, 32'h40, 3'd0, 1'b1));
    vecs.push_back(mk("jal_hi",      F_JL, 0, 26'h10, 0, 32'h1000_0040, 32'h40, 3'd1, 1'b1));
    vecs.push_back(mk("stall_ret",   F_S | F_RA, 32'h0, 0, 0, 32'h1000_0040, 32'h40, 3'd1, 1'b1));
    vecs.push_back(mk("exc_ret",     F_X | F_RA, 32'h0, 0, 0, 32'h8000_0180, 32'h1000_0040, 3'd1, 1'b1));
    vecs.push_back(mk("ret_after",   F_RA, 32'h0, 0, 0, 32'h1234_0004, 32'h1000_0040, 3'd0, 1'b1));
    vecs.push_back(mk("jr_top",      F_JR, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h1000_0040, 3'd0, 1'b1));
    vecs.push_back(mk("wrap",        F_NONE, 0, 0, 0, 32'h0, 32'h1000_0040, 3'd0, 1'b1));
    vecs.push_back(mk("br_maxpos",   F_BR, 0, 0, 16'h7FFF, 32'h0002_0000, 32'h1000_0040, 3'd0, 1'b1));
    vecs.push_back(mk("br_maxneg",   F_BR, 0, 0, 16'h8000, 32'h4, 32'h1000_0040, 3'd0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    mid_cycle_reset("reset2");
    step(mk("post_seq", F_NONE, 0, 0, 0, 32'h4, 32'h0, 3'd0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
